// File: rtl/seq_alu_if.sv
// Operand/request and result/status bundle between the register-file read
// stage, the sequential ALU and the write-back mux.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [3:0]       ALUOperation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, ALUOperation, A, B,
        input  ALUResult, Zero, Overflow, Busy, Done
    );

    modport slave (
        input  Start, ALUOperation, A, B,
        output ALUResult, Zero, Overflow, Busy, Done
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: logic/add/sub/move complete in one cycle, MUL/MULTPLUS run
// a WIDTH-step shift-add multiplier behind a start/busy/done handshake.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MULT = 1'b1;

    localparam logic [3:0] OP_AND      = 4'b0000;
    localparam logic [3:0] OP_OR       = 4'b0001;
    localparam logic [3:0] OP_NOR      = 4'b0010;
    localparam logic [3:0] OP_ADD      = 4'b0011;
    localparam logic [3:0] OP_SUB      = 4'b0100;
    localparam logic [3:0] OP_INC      = 4'b0101;
    localparam logic [3:0] OP_MULTPLUS = 4'b0110;
    localparam logic [3:0] OP_MOV      = 4'b0111;
    localparam logic [3:0] OP_ADDI     = 4'b1000;
    localparam logic [3:0] OP_MUL      = 4'b1001;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             plus_q, plus_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             is_mul;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mul_final;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        is_mul  = 1'b0;
        case (bus.ALUOperation)
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_NOR:  alu_res = ~(bus.A | bus.B);
            OP_ADD, OP_ADDI: begin
                alu_res = bus.A + bus.B;
                alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = bus.A - bus.B;
                alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_INC:  alu_res = bus.A + WIDTH'(1);
            OP_MOV:  alu_res = bus.B;
            OP_MUL, OP_MULTPLUS: is_mul = 1'b1;
            default: alu_res = '0;
        endcase
    end

    // The last iteration and the result write share one edge, so the
    // final product is taken from the combinational step, not acc_q.
    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_final = acc_step + {{(WIDTH-1){1'b0}}, plus_q};

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        plus_d   = plus_q;
        done_d   = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.Start) begin
                if (is_mul) begin
                    mcand_d  = bus.A;
                    mplier_d = bus.B;
                    acc_d    = '0;
                    cnt_d    = '0;
                    plus_d   = (bus.ALUOperation == OP_MULTPLUS);
                    state_d  = S_MULT;
                end else begin
                    res_d  = alu_res;
                    zero_d = (alu_res == '0);
                    ovf_d  = alu_ovf;
                    done_d = 1'b1;
                end
            end
        end else begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                res_d   = mul_final;
                zero_d  = (mul_final == '0);
                ovf_d   = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            plus_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            plus_q   <= plus_d;
        end
    end

    assign bus.ALUResult = res_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Done      = done_q;
    assign bus.Busy      = (state_q == S_MULT);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: one 32-bit and one 8-bit instance on a shared clock.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst32;
    logic rst8;
    int   total = 0;
    int   bad   = 0;

    seq_alu_if #(.WIDTH(32)) bus32();
    seq_alu_if #(.WIDTH(8))  bus8();

    seq_alu #(.WIDTH(32), .CNT_W(6)) dut32 (.clk(clk), .reset(rst32), .bus(bus32));
    seq_alu #(.WIDTH(8),  .CNT_W(4)) dut8  (.clk(clk), .reset(rst8),  .bus(bus8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the first post-Start cycle until Done is seen (1-based), bounded.
    task automatic wait_done(input bit w8, output int n, output int busy_cnt);
        n = 1;
        busy_cnt = 0;
        while (((w8 ? bus8.Done : bus32.Done) !== 1'b1) && n < 100) begin
            if ((w8 ? bus8.Busy : bus32.Busy) === 1'b1) busy_cnt++;
            tick();
            n++;
        end
    endtask

    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.Start = 1'b1; bus32.ALUOperation = op; bus32.A = a; bus32.B = b;
        tick();
        bus32.Start = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus8.Start = 1'b1; bus8.ALUOperation = op; bus8.A = a; bus8.B = b;
        tick();
        bus8.Start = 1'b0;
    endtask

    task automatic test_reset();
        rst32 = 1'b1; rst8 = 1'b1;
        tick();
        rst32 = 1'b0; rst8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus32.ALUResult !== 32'h0 || bus32.Zero !== 1'b1 || bus32.Busy !== 1'b0 ||
                bus32.Done !== 1'b0 || bus32.Overflow !== 1'b0) begin
                bad++;
                $display("FAIL reset32 cyc%0d: res=%h z=%b b=%b d=%b v=%b want res=0 z=1 b=0 d=0 v=0",
                         i, bus32.ALUResult, bus32.Zero, bus32.Busy, bus32.Done, bus32.Overflow);
            end
            total++;
            if (bus8.ALUResult !== 8'h0 || bus8.Zero !== 1'b1 || bus8.Busy !== 1'b0 || bus8.Done !== 1'b0) begin
                bad++;
                $display("FAIL reset8 cyc%0d: res=%h z=%b b=%b d=%b want res=0 z=1 b=0 d=0",
                         i, bus8.ALUResult, bus8.Zero, bus8.Busy, bus8.Done);
            end
            tick();
        end
    endtask

    task automatic test_add_sub();
        issue32(4'b0011, 32'h7FFFFFFF, 32'h1);
        total++;
        if (bus32.Done !== 1'b1 || bus32.ALUResult !== 32'h80000000 || bus32.Overflow !== 1'b1 ||
            bus32.Zero !== 1'b0 || bus32.Busy !== 1'b0) begin
            bad++;
            $display("FAIL add_ovf: d=%b res=%h v=%b z=%b b=%b want d=1 res=80000000 v=1 z=0 b=0",
                     bus32.Done, bus32.ALUResult, bus32.Overflow, bus32.Zero, bus32.Busy);
        end
        issue32(4'b0100, 32'h5, 32'h5);
        total++;
        if (bus32.Done !== 1'b1 || bus32.ALUResult !== 32'h0 || bus32.Zero !== 1'b1 || bus32.Overflow !== 1'b0) begin
            bad++;
            $display("FAIL sub_zero: d=%b res=%h z=%b v=%b want d=1 res=0 z=1 v=0",
                     bus32.Done, bus32.ALUResult, bus32.Zero, bus32.Overflow);
        end
        bus32.A = 32'hDEADBEEF; bus32.ALUOperation = 4'b0001;
        tick();
        total++;
        if (bus32.Done !== 1'b0 || bus32.ALUResult !== 32'h0 || bus32.Zero !== 1'b1) begin
            bad++;
            $display("FAIL hold: d=%b res=%h z=%b want d=0 res=0 z=1", bus32.Done, bus32.ALUResult, bus32.Zero);
        end
        issue32(4'b0100, 32'h80000000, 32'h1);
        total++;
        if (bus32.ALUResult !== 32'h7FFFFFFF || bus32.Overflow !== 1'b1) begin
            bad++;
            $display("FAIL sub_ovf: res=%h v=%b want res=7fffffff v=1", bus32.ALUResult, bus32.Overflow);
        end
        issue32(4'b1000, 32'hFFFFFFFF, 32'h2);
        total++;
        if (bus32.ALUResult !== 32'h1 || bus32.Overflow !== 1'b0) begin
            bad++;
            $display("FAIL addi: res=%h v=%b want res=1 v=0", bus32.ALUResult, bus32.Overflow);
        end
    endtask

    task automatic test_mul();
        int n, b;
        issue32(4'b1001, 32'h00010003, 32'h00020005);
        wait_done(1'b0, n, b);
        total++;
        if (n != 33 || b != 32 || bus32.Busy !== 1'b0) begin
            bad++;
            $display("FAIL mul_lat: done_at=%0d busy_cycles=%0d busy_now=%b want 33 32 0", n, b, bus32.Busy);
        end
        total++;
        if (bus32.ALUResult !== 32'h000B000F || bus32.Zero !== 1'b0 || bus32.Overflow !== 1'b0) begin
            bad++;
            $display("FAIL mul_res: res=%h z=%b v=%b want 000b000f 0 0", bus32.ALUResult, bus32.Zero, bus32.Overflow);
        end
        issue32(4'b0110, 32'hFFFFFFFF, 32'h1);
        wait_done(1'b0, n, b);
        total++;
        if (n != 33 || bus32.ALUResult !== 32'h0 || bus32.Zero !== 1'b1) begin
            bad++;
            $display("FAIL multplus_wrap: done_at=%0d res=%h z=%b want 33 0 1", n, bus32.ALUResult, bus32.Zero);
        end
    endtask

    task automatic test_busy_ignore();
        int n = 1;
        issue32(4'b1001, 32'h3, 32'h7);
        bus32.Start = 1'b1; bus32.ALUOperation = 4'b0000;
        while (bus32.Done !== 1'b1 && n < 100) begin
            bus32.A = $urandom; bus32.B = $urandom;
            tick();
            n++;
        end
        total++;
        if (n != 33 || bus32.ALUResult !== 32'h15 || bus32.Busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore: done_at=%0d res=%h busy=%b want 33 00000015 0", n, bus32.ALUResult, bus32.Busy);
        end
        bus32.A = 32'hF0F0F0F0; bus32.B = 32'hFF00FF00;
        tick();
        bus32.Start = 1'b0;
        total++;
        if (bus32.Done !== 1'b1 || bus32.ALUResult !== 32'hF000F000 || bus32.Busy !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done: d=%b res=%h b=%b want 1 f000f000 0", bus32.Done, bus32.ALUResult, bus32.Busy);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        issue32(4'b1001, 32'h1234, 32'h10);
        for (int i = 0; i < 9; i++) tick();
        rst32 = 1'b1;
        bus32.Start = 1'b1; bus32.ALUOperation = 4'b0011; bus32.A = 32'h1; bus32.B = 32'h1;
        tick();
        rst32 = 1'b0; bus32.Start = 1'b0;
        total++;
        if (bus32.Busy !== 1'b0 || bus32.ALUResult !== 32'h0 || bus32.Zero !== 1'b1 || bus32.Done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: b=%b res=%h z=%b d=%b want 0 0 1 0",
                     bus32.Busy, bus32.ALUResult, bus32.Zero, bus32.Done);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus32.Done === 1'b1 || bus32.Busy === 1'b1) dones++;
            tick();
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL reset_abort: activity_cycles=%0d want 0", dones);
        end
        issue32(4'b0010, 32'h0, 32'h0);
        total++;
        if (bus32.Done !== 1'b1 || bus32.ALUResult !== 32'hFFFFFFFF || bus32.Zero !== 1'b0) begin
            bad++;
            $display("FAIL nor: d=%b res=%h z=%b want 1 ffffffff 0", bus32.Done, bus32.ALUResult, bus32.Zero);
        end
    endtask

    task automatic test_back_to_back();
        bus32.Start = 1'b1; bus32.ALUOperation = 4'b0101; bus32.A = 32'h7FFFFFFF;
        tick();
        total++;
        if (bus32.Done !== 1'b1 || bus32.ALUResult !== 32'h80000000 || bus32.Overflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_inc: d=%b res=%h v=%b want 1 80000000 0", bus32.Done, bus32.ALUResult, bus32.Overflow);
        end
        bus32.A = 32'hFFFFFFFF;
        tick();
        total++;
        if (bus32.Done !== 1'b1 || bus32.ALUResult !== 32'h0 || bus32.Zero !== 1'b1) begin
            bad++;
            $display("FAIL b2b_inc_wrap: d=%b res=%h z=%b want 1 0 1", bus32.Done, bus32.ALUResult, bus32.Zero);
        end
        bus32.ALUOperation = 4'b0111; bus32.B = 32'h1234;
        tick();
        bus32.Start = 1'b0;
        total++;
        if (bus32.Done !== 1'b1 || bus32.ALUResult !== 32'h1234) begin
            bad++;
            $display("FAIL b2b_mov: d=%b res=%h want 1 00001234", bus32.Done, bus32.ALUResult);
        end
        tick();
        total++;
        if (bus32.Done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: d=%b want 0", bus32.Done);
        end
    endtask

    task automatic test_width8();
        int n, b;
        issue8(4'b1001, 8'h10, 8'h10);
        wait_done(1'b1, n, b);
        total++;
        if (n != 9 || b != 8 || bus8.ALUResult !== 8'h00 || bus8.Zero !== 1'b1) begin
            bad++;
            $display("FAIL w8_mul: done_at=%0d busy=%0d res=%h z=%b want 9 8 00 1", n, b, bus8.ALUResult, bus8.Zero);
        end
        issue8(4'b0011, 8'h7F, 8'h01);
        total++;
        if (bus8.ALUResult !== 8'h80 || bus8.Overflow !== 1'b1) begin
            bad++;
            $display("FAIL w8_add: res=%h v=%b want 80 1", bus8.ALUResult, bus8.Overflow);
        end
        issue8(4'b1111, 8'hAA, 8'h55);
        total++;
        if (bus8.Done !== 1'b1 || bus8.ALUResult !== 8'h00 || bus8.Zero !== 1'b1 || bus8.Overflow !== 1'b0) begin
            bad++;
            $display("FAIL w8_illegal: d=%b res=%h z=%b v=%b want 1 00 1 0",
                     bus8.Done, bus8.ALUResult, bus8.Zero, bus8.Overflow);
        end
        // Start held: a second MUL is captured on the first one's Done cycle.
        bus8.Start = 1'b1; bus8.ALUOperation = 4'b1001; bus8.A = 8'h3; bus8.B = 8'h5;
        tick();
        wait_done(1'b1, n, b);
        total++;
        if (n != 9 || bus8.ALUResult !== 8'h0F) begin
            bad++;
            $display("FAIL w8_held1: done_at=%0d res=%h want 9 0f", n, bus8.ALUResult);
        end
        bus8.A = 8'h4; bus8.B = 8'h4;
        tick();
        bus8.Start = 1'b0;
        total++;
        if (bus8.Busy !== 1'b1 || bus8.Done !== 1'b0) begin
            bad++;
            $display("FAIL w8_held_busy: b=%b d=%b want 1 0", bus8.Busy, bus8.Done);
        end
        wait_done(1'b1, n, b);
        total++;
        if (n != 9 || bus8.ALUResult !== 8'h10) begin
            bad++;
            $display("FAIL w8_held2: done_at=%0d res=%h want 9 10", n, bus8.ALUResult);
        end
    endtask

    initial begin
        rst32 = 1'b1; rst8 = 1'b1;
        bus32.Start = 1'b0; bus32.ALUOperation = 4'b0; bus32.A = '0; bus32.B = '0;
        bus8.Start  = 1'b0; bus8.ALUOperation  = 4'b0; bus8.A  = '0; bus8.B  = '0;
        #2;
        test_reset();
        test_add_sub();
        test_mul();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
